// File: rtl/sum_diff_pkg.sv
// sum_diff_pkg: default fixed-point formats of the sum/difference decoder and
// helpers that size its exact (lossless) internal datapath.
package sum_diff_pkg;

    localparam int SD_S_WIDTH    = 18;
    localparam int SD_S_EXPONENT = -10;
    localparam int SD_D_WIDTH    = 19;
    localparam int SD_D_EXPONENT = -11;
    localparam int SD_A_WIDTH    = 16;
    localparam int SD_A_EXPONENT = -8;
    localparam int SD_B_WIDTH    = 17;
    localparam int SD_B_EXPONENT = -9;

    function automatic int sd_min_exp(input int s_exp, input int d_exp);
        return (s_exp < d_exp) ? s_exp : d_exp;
    endfunction

    // Width of an operand once left-shifted to the common (finer) exponent.
    function automatic int sd_aligned_width(input int s_w, input int s_exp,
                                            input int d_w, input int d_exp);
        int e;
        int sa;
        int da;
        e  = sd_min_exp(s_exp, d_exp);
        sa = s_w + (s_exp - e);
        da = d_w + (d_exp - e);
        return (sa > da) ? sa : da;
    endfunction

    // One guard bit so that s+d and s-d can never overflow.
    function automatic int sd_sum_width(input int s_w, input int s_exp,
                                        input int d_w, input int d_exp);
        return sd_aligned_width(s_w, s_exp, d_w, d_exp) + 1;
    endfunction

endpackage

// File: rtl/svreal_rescale_sat.sv
// svreal_rescale_sat: move a signed fixed-point value to a new exponent,
// rounding half-up on right shifts and clamping to the output range.
module svreal_rescale_sat #(
    parameter int IN_WIDTH  = 20,
    parameter int IN_EXP    = -12,
    parameter int OUT_WIDTH = 16,
    parameter int OUT_EXP   = -8
) (
    input  logic signed [IN_WIDTH-1:0]  i_value,
    output logic signed [OUT_WIDTH-1:0] o_value,
    output logic                        o_sat
);

    localparam int K  = OUT_EXP - IN_EXP;
    localparam int W  = (K > 0) ? (((IN_WIDTH > K) ? IN_WIDTH : K) + 1) : (IN_WIDTH - K);
    localparam int WC = ((W > OUT_WIDTH) ? W : OUT_WIDTH) + 1;
    localparam logic signed [WC-1:0] MAXV = {{(WC-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [WC-1:0] MINV = {{(WC-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [W-1:0]  w_ext;
    logic signed [W-1:0]  w_scaled;
    logic signed [WC-1:0] w_wide;
    logic                 w_hi;
    logic                 w_lo;

    assign w_ext = W'(i_value);

    generate
        if (K > 0) begin : g_round
            localparam logic signed [W-1:0] HALF = W'(1) << (K - 1);
            assign w_scaled = (w_ext + HALF) >>> K;
        end else begin : g_shl
            assign w_scaled = w_ext <<< (-K);
        end
    endgenerate

    assign w_wide  = WC'(w_scaled);
    assign w_hi    = w_wide > MAXV;
    assign w_lo    = w_wide < MINV;
    assign o_sat   = w_hi | w_lo;
    assign o_value = w_hi ? MAXV[OUT_WIDTH-1:0] : (w_lo ? MINV[OUT_WIDTH-1:0] : w_wide[OUT_WIDTH-1:0]);

endmodule

// File: rtl/sum_diff_decoder.sv
// sum_diff_decoder: recovers a=(s+d)/2 and b=(s-d)/2 through a two-stage
// valid/ready pipeline (exact add/sub, then halve, rescale and saturate).
module sum_diff_decoder
    import sum_diff_pkg::*;
#(
    parameter int S_WIDTH    = SD_S_WIDTH,
    parameter int S_EXPONENT = SD_S_EXPONENT,
    parameter int D_WIDTH    = SD_D_WIDTH,
    parameter int D_EXPONENT = SD_D_EXPONENT,
    parameter int A_WIDTH    = SD_A_WIDTH,
    parameter int A_EXPONENT = SD_A_EXPONENT,
    parameter int B_WIDTH    = SD_B_WIDTH,
    parameter int B_EXPONENT = SD_B_EXPONENT
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic signed [S_WIDTH-1:0] s_value,
    input  logic signed [D_WIDTH-1:0] d_value,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [A_WIDTH-1:0] a_value,
    output logic signed [B_WIDTH-1:0] b_value,
    output logic                      sat,
    output logic [15:0]               sat_count
);

    localparam int E     = sd_min_exp(S_EXPONENT, D_EXPONENT);
    localparam int SUM_W = sd_sum_width(S_WIDTH, S_EXPONENT, D_WIDTH, D_EXPONENT);

    logic signed [SUM_W-1:0]   w_s_al;
    logic signed [SUM_W-1:0]   w_d_al;
    logic signed [SUM_W-1:0]   r_sum;
    logic signed [SUM_W-1:0]   r_diff;
    logic                      r_s1_valid;
    logic                      w_adv1;
    logic                      w_adv2;
    logic signed [A_WIDTH-1:0] w_a;
    logic signed [B_WIDTH-1:0] w_b;
    logic                      w_sat_a;
    logic                      w_sat_b;

    assign w_s_al = SUM_W'(s_value) <<< (S_EXPONENT - E);
    assign w_d_al = SUM_W'(d_value) <<< (D_EXPONENT - E);

    assign w_adv2   = !out_valid || out_ready;
    assign w_adv1   = !r_s1_valid || w_adv2;
    assign in_ready = w_adv1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_sum      <= '0;
            r_diff     <= '0;
        end else if (w_adv1) begin
            r_s1_valid <= in_valid;
            r_sum      <= w_s_al + w_d_al;
            r_diff     <= w_s_al - w_d_al;
        end
    end

    // Halving is free: the stage-1 results are simply read at exponent E-1.
    svreal_rescale_sat #(
        .IN_WIDTH (SUM_W),
        .IN_EXP   (E - 1),
        .OUT_WIDTH(A_WIDTH),
        .OUT_EXP  (A_EXPONENT)
    ) u_rescale_a (
        .i_value(r_sum),
        .o_value(w_a),
        .o_sat  (w_sat_a)
    );

    svreal_rescale_sat #(
        .IN_WIDTH (SUM_W),
        .IN_EXP   (E - 1),
        .OUT_WIDTH(B_WIDTH),
        .OUT_EXP  (B_EXPONENT)
    ) u_rescale_b (
        .i_value(r_diff),
        .o_value(w_b),
        .o_sat  (w_sat_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            a_value   <= '0;
            b_value   <= '0;
            sat       <= 1'b0;
        end else if (w_adv2) begin
            out_valid <= r_s1_valid;
            a_value   <= w_a;
            b_value   <= w_b;
            sat       <= w_sat_a | w_sat_b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && sat && sat_count != 16'hFFFF) begin
            sat_count <= sat_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_sum_diff_decoder.sv
// tb_sum_diff_decoder: directed and randomized valid/ready checks of
// sum_diff_decoder against an arithmetic reference model and scoreboard.
module tb_sum_diff_decoder;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic signed [17:0] s_value = '0;
    logic signed [18:0] d_value = '0;
    logic               in_ready;
    logic               out_valid;
    logic signed [15:0] a_value;
    logic signed [16:0] b_value;
    logic               sat;
    logic [15:0]        sat_count;

    typedef struct {
        longint a;
        longint b;
        bit     sat;
    } beat_t;

    beat_t  q[$];
    int     n_chk = 0;
    int     n_fail = 0;
    longint exp_cnt = 0;
    bit     hold_prev = 0;
    longint prev_a, prev_b, prev_sat;

    sum_diff_decoder dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .s_value  (s_value),
        .d_value  (d_value),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .a_value  (a_value),
        .b_value  (b_value),
        .sat      (sat),
        .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint fdiv(input longint x, input longint m);
        return (x >= 0) ? x / m : -((-x + m - 1) / m);
    endfunction

    // (s+d)/2 and (s-d)/2 in units of 2^-12 are 2s+d and 2s-d; then round to 2^-8 / 2^-9.
    function automatic beat_t model(input longint s, input longint d);
        beat_t  r;
        longint a, b;
        a = fdiv(2 * s + d + 8, 16);
        b = fdiv(2 * s - d + 4, 8);
        r.sat = (a > 32767) || (a < -32768) || (b > 65535) || (b < -65536);
        r.a = (a > 32767) ? 32767 : (a < -32768) ? -32768 : a;
        r.b = (b > 65535) ? 65535 : (b < -65536) ? -65536 : b;
        return r;
    endfunction

    // Called just after the inputs are driven at a negedge; ends at the next negedge.
    task automatic step(output bit acc);
        bit    con;
        beat_t e;
        #1;
        chk("sat_count", sat_count, exp_cnt);
        if (hold_prev) begin
            chk("hold_a", a_value, prev_a);
            chk("hold_b", b_value, prev_b);
            chk("hold_sat", sat, prev_sat);
        end
        acc = in_valid && in_ready;
        con = out_valid && out_ready;
        if (con) begin
            if (q.size() == 0) begin
                chk("spurious_beat", 1, 0);
            end else begin
                e = q.pop_front();
                chk("a", a_value, e.a);
                chk("b", b_value, e.b);
                chk("sat", sat, e.sat);
                if (e.sat && exp_cnt < 65535) exp_cnt++;
            end
        end
        if (acc) q.push_back(model(s_value, d_value));
        hold_prev = out_valid && !out_ready;
        prev_a    = a_value;
        prev_b    = b_value;
        prev_sat  = sat;
        @(negedge clk);
    endtask

    task automatic rand_beat();
        case ($urandom_range(0, 7))
            0:       s_value = 18'sh1FFFF;
            1:       s_value = -18'sh20000;
            default: s_value = 18'($urandom());
        endcase
        case ($urandom_range(0, 7))
            0:       d_value = 19'sh3FFFF;
            1:       d_value = -19'sh40000;
            default: d_value = 19'($urandom());
        endcase
    endtask

    task automatic one_beat(input longint s, input longint d,
                            input longint ea, input longint eb, input longint es, input string tag);
        bit acc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        s_value   = 18'(s);
        d_value   = 19'(d);
        step(acc);
        chk({tag, "_acc"}, acc, 1);
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        step(acc);
        chk({tag, "_valid"}, out_valid, 1);
        chk({tag, "_a"}, a_value, ea);
        chk({tag, "_b"}, b_value, eb);
        chk({tag, "_sat"}, sat, es);
        step(acc);
    endtask

    longint bp_s[3] = '{100, -2000, 50000};
    longint bp_d[3] = '{300, 7000, -12345};

    initial begin
        bit acc;
        int sent;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            in_valid  = 1'($urandom());
            out_ready = 1'($urandom());
            rand_beat();
            #1;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_in_ready", in_ready, 1);
            chk("rst_sat_count", sat_count, 0);
            chk("rst_a", a_value, 0);
            chk("rst_b", b_value, 0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        one_beat(1536, 1024, 256, 256, 0, "basic");
        one_beat(131071, 262143, 32767, 0, 1, "round_sat");
        @(negedge clk);
        #1;
        chk("round_sat_count", sat_count, 1);
        @(negedge clk);

        out_ready = 1'b0;
        sent = 0;
        for (int c = 0; c < 10 && sent < 2; c++) begin
            in_valid = 1'b1;
            s_value  = 18'(bp_s[sent]);
            d_value  = 19'(bp_d[sent]);
            step(acc);
            if (acc) sent++;
        end
        s_value = 18'(bp_s[2]);
        d_value = 19'(bp_d[2]);
        #1;
        chk("bp_in_ready", in_ready, 0);
        for (int c = 0; c < 3; c++) step(acc);
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            in_valid = (sent < 3);
            if (sent < 3) begin
                s_value = 18'(bp_s[sent]);
                d_value = 19'(bp_d[sent]);
            end
            step(acc);
            if (acc) sent++;
            if (sent == 3 && q.size() == 0) break;
        end
        in_valid = 1'b0;
        chk("bp_drained", q.size(), 0);
        chk("bp_sent", sent, 3);

        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            in_valid = 1'b1;
            rand_beat();
            step(acc);
        end
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_sat_count", sat_count, 0);
        q.delete();
        exp_cnt   = 0;
        hold_prev = 0;
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step(acc);
            chk("midrst_no_output", out_valid, 0);
        end
        one_beat(1536, 1024, 256, 256, 0, "post_rst");

        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            rand_beat();
            step(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 20 && q.size() != 0; c++) step(acc);
        chk("final_drained", q.size(), 0);
        #1;
        chk("final_out_valid", out_valid, 0);
        chk("final_sat_count", sat_count, exp_cnt);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sum_diff_decoder.md
SUM_DIFF_DECODER -- requirements
Module: sum_diff_decoder

Interface
REQ-001 The block SHALL have parameter S_WIDTH, default 18: width of the signed sum input s.
REQ-002 The block SHALL have parameter S_EXPONENT, default -10: exponent of s (real = value*2^exp).
REQ-003 The block SHALL have parameter D_WIDTH, default 19: width of the signed difference input d.
REQ-004 The block SHALL have parameter D_EXPONENT, default -11: exponent of d.
REQ-005 The block SHALL have parameter A_WIDTH, default 16: width of the signed output a.
REQ-006 The block SHALL have parameter A_EXPONENT, default -8: exponent of a.
REQ-007 The block SHALL have parameter B_WIDTH, default 17: width of the signed output b.
REQ-008 The block SHALL have parameter B_EXPONENT, default -9: exponent of b.
REQ-009 The block SHALL have ports: clk in 1 clock; rst_n in 1 reset (one clock, reset asynchronous and active-low).
REQ-010 The block SHALL have ports: in_valid in 1; in_ready out 1; s_value in S_WIDTH signed; d_value in D_WIDTH signed.
REQ-011 The block SHALL have ports: out_valid out 1; out_ready in 1; a_value out A_WIDTH signed; b_value out B_WIDTH signed.
REQ-012 The block SHALL have ports: sat out 1, saturation flag of the presented beat; sat_count out 16, count of saturated beats.

Function
REQ-013 The block SHALL recover a=(s+d)/2 and b=(s-d)/2 from each accepted (s,d) pair; it is the inverse of the sum/difference stage.
REQ-014 An input beat SHALL be accepted when in_valid and in_ready are both high at a rising clk edge.
REQ-015 An output beat SHALL be consumed when out_valid and out_ready are both high at a rising clk edge.
REQ-016 Stage 1 SHALL align s and d to E=min(S_EXPONENT,D_EXPONENT) by left shift and register s+d and s-d at full width (max aligned width + 1), with no loss.
REQ-017 Stage 2 SHALL treat the stage-1 results as having exponent E-1 (the halving), then rescale each to its output exponent.
REQ-018 Rescaling by right shift k>0 SHALL round half-up: add 2^(k-1), then arithmetic shift right by k. Rescaling by k<=0 SHALL left shift, with no rounding.
REQ-019 A rescaled value outside the output range SHALL clamp to that range's max or min. sat SHALL be high for the beat if either a or b clamped.
REQ-020 Latency SHALL be 2 cycles from acceptance to out_valid when out_ready is held high; throughput SHALL be 1 beat per cycle.
REQ-021 Each stage SHALL advance when its output register is empty or is being drained in the same cycle; in_ready SHALL equal the stage-1 advance condition, combinationally.
REQ-022 While out_valid is high and out_ready is low, a_value, b_value and sat SHALL hold stable.
REQ-023 Beats SHALL be neither dropped nor duplicated, and order SHALL be preserved under any valid/ready pattern.
REQ-024 A simultaneous accept and consume with both stages full SHALL shift the pipeline with no bubble.
REQ-025 sat_count SHALL increment by 1 on each consumed beat with sat=1 and SHALL stop at 0xFFFF, with no wrap-around.

Reset
REQ-026 Assertion of rst_n low SHALL immediately clear both stage valids; out_valid=0, a_value=0, b_value=0, sat=0, sat_count=0.
REQ-027 in_ready SHALL be 1 during and after reset.
REQ-028 Beats in flight at reset SHALL be discarded. The first beat accepted after release SHALL appear 2 cycles later.

Structure
REQ-029 A package sum_diff_pkg SHALL hold the default format constants and a function computing the aligned and sum widths.
REQ-030 Rescale, round and saturate SHALL be one sub-module, svreal_rescale_sat, with in/out width and exponent parameters, a sat output, and two instances (a, b).
REQ-031 Datapath registers SHALL carry no enable beyond the stage-advance condition.

Verification
REQ-032 Reset: hold rst_n=0 with random inputs -> out_valid=0, in_ready=1, sat_count=0, a_value=b_value=0.
REQ-033 Basic: s=1536, d=1024, out_ready=1 -> 2 cycles later a_value=256, b_value=256 (1.0, 0.5), sat=0.
REQ-034 Rounding/saturate: s=131071, d=262143 -> a_value=32767 with sat=1 (32767.8 rounds to 32768, clamped); b_value=0; sat_count=1 after consume.
REQ-035 Backpressure: send 3 beats with out_ready=0 -> in_ready=0 after 2 beats accepted; outputs stable; releasing out_ready delivers all 3 in order.
REQ-036 Reset mid-operation: 2 beats in flight, pulse rst_n low -> no output from those beats; a new beat s=1536, d=1024 yields a=256, b=256 in 2 cycles.
REQ-037 Random stream: random valid/ready toggling against a reference model -> zero mismatches and exact sat_count.
